// File: rtl/dvi_pkg.sv
// Shared DVI/TMDS definitions used by the transmit and receive paths.
//   COLOR_W            decoded pixel data width (fixed at 8 by TMDS)
//   CTRL_TOKEN_xx      10-bit control tokens, written as symbol[9:0]
//   tmds_align_state_t receive-side word-alignment FSM states
package dvi_pkg;

  localparam int COLOR_W = 8;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    SLIP_WAIT = 2'd1,
    LOCKED    = 2'd2
  } tmds_align_state_t;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Purely combinational TMDS symbol decoder.
//   symbol_i   [9:0]        raw aligned symbol, bit 0 first on the wire
//   is_token_o              symbol is one of the four control tokens
//   ctrl_o     [1:0]        {c1,c0} of the token (0 when not a token)
//   data_o     [COLOR_W-1:0] 8b/10b-TMDS decoded data (valid when not a token)
module tmds_symbol_decode
  import dvi_pkg::*;
(
  input  logic [9:0]         symbol_i,
  output logic               is_token_o,
  output logic [1:0]         ctrl_o,
  output logic [COLOR_W-1:0] data_o
);

  logic [COLOR_W-1:0] p;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    is_token_o = 1'b1;
    ctrl_o     = 2'b00;
    unique case (symbol_i)
      CTRL_TOKEN_00: ctrl_o = 2'b00;
      CTRL_TOKEN_01: ctrl_o = 2'b01;
      CTRL_TOKEN_10: ctrl_o = 2'b10;
      CTRL_TOKEN_11: ctrl_o = 2'b11;
      default:       is_token_o = 1'b0;
    endcase
  end

  // q[9] marks an inverted payload; q[8] selects XOR vs XNOR chaining.
  always_comb begin
    p         = symbol_i[9] ? ~symbol_i[7:0] : symbol_i[7:0];
    data_o    = '0;
    data_o[0] = p[0];
    for (int i = 1; i < COLOR_W; i++) begin
      data_o[i] = symbol_i[8] ? (p[i] ^ p[i-1]) : ~(p[i] ^ p[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// Single-channel TMDS receive decoder with word-alignment search.
//   clk_i      pixel clock, same domain as the deserializer parallel word
//   rst_n_i    asynchronous active-low reset
//   symbol_i   [9:0] raw symbol from the deserializer, bit 0 first on wire
//   bitslip_o  one-cycle pulse asking the deserializer to shift by one bit
//   locked_o   word alignment achieved
//   data_o     [COLOR_W-1:0] decoded pixel data (0 unless locked video)
//   ctrl_o     [1:0] decoded {c1,c0}, held across video periods
//   de_o       data enable, 1 on video symbols while locked
module tmds_decoder
  import dvi_pkg::*;
#(
  parameter int LOCK_TOKENS    = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_SETTLE    = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [9:0]         symbol_i,
  output logic               bitslip_o,
  output logic               locked_o,
  output logic [COLOR_W-1:0] data_o,
  output logic [1:0]         ctrl_o,
  output logic               de_o
);

  localparam int CNT_W = $clog2(SEARCH_TIMEOUT + 1);
  localparam int SET_W = $clog2(SLIP_SETTLE + 1);

  logic               is_token;
  logic [1:0]         tok_ctrl;
  logic [COLOR_W-1:0] dec_data;

  tmds_symbol_decode u_decode (
    .symbol_i   (symbol_i),
    .is_token_o (is_token),
    .ctrl_o     (tok_ctrl),
    .data_o     (dec_data)
  );

  tmds_align_state_t  state_q, state_d;
  logic [CNT_W-1:0]   run_q, run_d, tmo_q, tmo_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               bitslip_q, bitslip_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic               de_q, de_d;

  logic [CNT_W-1:0] run_next;
  logic             run_done;
  logic             timeout;

  // run_cnt saturates at LOCK_TOKENS so "run complete" fires once per run.
  assign run_next = !is_token                   ? '0 :
                    (run_q == CNT_W'(LOCK_TOKENS)) ? run_q : run_q + 1'b1;
  assign run_done = is_token && (run_q == CNT_W'(LOCK_TOKENS - 1));
  assign timeout  = (tmo_q == CNT_W'(SEARCH_TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    run_d     = run_next;
    tmo_d     = tmo_q + 1'b1;
    settle_d  = '0;
    bitslip_d = 1'b0;

    unique case (state_q)
      SEARCH: begin
        // Run complete has priority over a coincident timeout.
        if (run_done) begin
          state_d = LOCKED;
          run_d   = '0;
          tmo_d   = '0;
        end else if (timeout) begin
          state_d   = SLIP_WAIT;
          bitslip_d = 1'b1;
          run_d     = '0;
          tmo_d     = '0;
        end
      end
      SLIP_WAIT: begin
        // The deserializer output is unsettled here; ignore symbols.
        run_d = '0;
        tmo_d = '0;
        if (settle_q == SET_W'(SLIP_SETTLE - 1)) state_d = SEARCH;
        else                                     settle_d = settle_q + 1'b1;
      end
      LOCKED: begin
        if (run_done) begin
          tmo_d = '0;
        end else if (timeout) begin
          // Loss of lock re-enters search without slipping; the next
          // slip only follows another full timeout.
          state_d = SEARCH;
          run_d   = '0;
          tmo_d   = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        run_d   = '0;
        tmo_d   = '0;
      end
    endcase
  end

  // Output registers follow the next state so locked_o and the first
  // locked decode appear on the same cycle.
  always_comb begin
    data_d = '0;
    ctrl_d = 2'b00;
    de_d   = 1'b0;
    if (state_d == LOCKED) begin
      if (is_token) begin
        ctrl_d = tok_ctrl;
      end else begin
        de_d   = 1'b1;
        data_d = dec_data;
        ctrl_d = ctrl_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: all registers here are control/datapath state that must be in a
  // known value after reset, so each one is asynchronously cleared.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= SEARCH;
      run_q     <= '0;
      tmo_q     <= '0;
      settle_q  <= '0;
      bitslip_q <= 1'b0;
      data_q    <= '0;
      ctrl_q    <= 2'b00;
      de_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      tmo_q     <= tmo_d;
      settle_q  <= settle_d;
      bitslip_q <= bitslip_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      de_q      <= de_d;
    end
  end

  assign bitslip_o = bitslip_q;
  assign locked_o  = (state_q == LOCKED);
  assign data_o    = data_q;
  assign ctrl_o    = ctrl_q;
  assign de_o      = de_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed self-checking bench for tmds_decoder.
module tb_tmds_decoder;
  import dvi_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_n_i = 1'b0;
  logic [9:0]         symbol_i = '0;
  logic               bitslip_o;
  logic               locked_o;
  logic [COLOR_W-1:0] data_o;
  logic [1:0]         ctrl_o;
  logic               de_o;

  int n_tests = 0;
  int n_fail  = 0;

  tmds_decoder dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .symbol_i  (symbol_i),
    .bitslip_o (bitslip_o),
    .locked_o  (locked_o),
    .data_o    (data_o),
    .ctrl_o    (ctrl_o),
    .de_o      (de_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_n_i  = 1'b0;
    symbol_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  function automatic logic [9:0] rot(input logic [9:0] s, input int r);
    logic [9:0] v = s;
    for (int k = 0; k < r; k++) v = {v[8:0], v[9]};
    return v;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] v = 10'($urandom);
    if (v == CTRL_TOKEN_00 || v == CTRL_TOKEN_01 ||
        v == CTRL_TOKEN_10 || v == CTRL_TOKEN_11) v = v ^ 10'd1;
    return v;
  endfunction

  initial begin
    int r, cyc, nslip, last_slip, lock_cyc;
    bit seen_slip, ok;

    // ---------------- reset values and basic lock ----------------
    do_reset();
    check("rst_locked", locked_o, 0);
    check("rst_bitslip", bitslip_o, 0);
    check("rst_outs", {data_o, ctrl_o, de_o}, 0);

    seen_slip = 0;
    symbol_i  = CTRL_TOKEN_00;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (bitslip_o) seen_slip = 1;
      if (k == 7) check("lock_before_8th", locked_o, 0);
      if (k == 8) check("lock_after_8th", locked_o, 1);
    end
    check("lock_ctrl00", ctrl_o, 2'b00);
    check("lock_de0", de_o, 0);
    check("lock_no_slip", seen_slip, 0);

    // ---------------- data decode while locked ----------------
    symbol_i = 10'b0100000000; step();
    check("dec_de", de_o, 1);
    check("dec_0100000000", data_o, 8'h00);
    symbol_i = 10'b1011111111; step();
    check("dec_1011111111", data_o, 8'hFE);
    symbol_i = 10'b0100000001; step();
    check("dec_0100000001", data_o, 8'h03);
    symbol_i = 10'b0000000001; step();
    check("dec_0000000001", data_o, 8'hFD);
    symbol_i = 10'b1111111110; step();
    check("dec_1111111110", data_o, 8'h03);

    // token 11 then video: ctrl held, de high
    symbol_i = CTRL_TOKEN_11; step();
    check("tok11_ctrl", ctrl_o, 2'b11);
    check("tok11_de", {de_o, data_o}, 0);
    symbol_i = 10'b0100000000; step();
    check("hold_ctrl", ctrl_o, 2'b11);
    check("hold_de", de_o, 1);
    symbol_i = CTRL_TOKEN_10; step();
    check("tok10_ctrl", ctrl_o, 2'b10);
    symbol_i = CTRL_TOKEN_01; step();
    check("tok01_ctrl", ctrl_o, 2'b01);

    // ---------------- async reset mid-LOCKED ----------------
    symbol_i = 10'b0000000001; step();
    check("pre_rst_de", de_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("async_rst_locked", {locked_o, de_o, bitslip_o}, 0);
    check("async_rst_data", {data_o, ctrl_o}, 0);
    #1 rst_n_i = 1'b1;
    symbol_i = CTRL_TOKEN_00;
    for (int k = 1; k <= 8; k++) step();
    check("relock_after_rst", locked_o, 1);

    // ---------------- alignment search with model deserializer ----------------
    do_reset();
    r = 3;
    symbol_i = rot(CTRL_TOKEN_00, r);
    nslip = 0; last_slip = 0; lock_cyc = 0; ok = 1;
    for (cyc = 1; cyc <= 20000; cyc++) begin
      step();
      if (bitslip_o) begin
        nslip++;
        if (nslip == 1 && cyc != 2048) ok = 0;
        if (nslip > 1 && (cyc - last_slip) != 2052) ok = 0;
        last_slip = cyc;
        r = (r + 1) % 10;
        symbol_i = rot(CTRL_TOKEN_00, r);
      end
      if (locked_o) begin
        lock_cyc = cyc;
        break;
      end
    end
    check("slip_intervals", ok, 1);
    check("slip_count", nslip, 7);
    check("slip_lock_cycle", lock_cyc, 14372);
    symbol_i = rot(10'b0100000001, r); step();
    check("slip_data", {de_o, data_o}, {1'b1, 8'h03});

    // ---------------- glitch inside blanking ----------------
    do_reset();
    symbol_i = CTRL_TOKEN_00;
    for (int k = 0; k < 7; k++) step();
    symbol_i = 10'b1011111111; step();
    check("unlocked_data_zero", {de_o, data_o, ctrl_o}, 0);
    symbol_i = CTRL_TOKEN_00;
    for (int k = 0; k < 7; k++) step();
    check("glitch_no_lock", locked_o, 0);
    step();
    check("glitch_then_lock", locked_o, 1);

    // ---------------- loss of lock on video-only stream ----------------
    do_reset();
    symbol_i = CTRL_TOKEN_00;
    for (int k = 0; k < 8; k++) step();
    check("tmo_locked", locked_o, 1);
    cyc = 0;
    for (int k = 1; k <= 3000; k++) begin
      symbol_i = rand_data();
      step();
      if (k == 1) check("tmo_video_de", de_o, 1);
      if (!locked_o) begin
        cyc = k;
        check("tmo_fall_no_slip", bitslip_o, 0);
        break;
      end
    end
    check("tmo_fall_cycle", cyc, 2048);
    cyc = 0;
    for (int k = 1; k <= 3000; k++) begin
      symbol_i = rand_data();
      step();
      if (bitslip_o) begin
        cyc = k;
        break;
      end
    end
    check("tmo_first_slip", cyc, 2048);

    // ---------------- async reset during bitslip pulse ----------------
    check("pulse_high", bitslip_o, 1);
    rst_n_i = 1'b0;
    #1;
    check("rst_in_pulse", {bitslip_o, locked_o, de_o, data_o, ctrl_o}, 0);
    #1 rst_n_i = 1'b1;
    symbol_i = CTRL_TOKEN_00;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 7) check("search_after_rst7", locked_o, 0);
    end
    check("search_after_rst8", locked_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
